// File: rtl/emu_step_ctrl.sv
// emu_step_ctrl: run-control sequencer for emulated state registers.
// Produces the shared clock-enable (cke) and synchronous emulator reset
// (emu_rst). Host commands free-run, stop, advance N steps, or reset the
// emulated state. Steps are paced by a divider and can be stalled by hold.
module emu_step_ctrl #(
  parameter int cnt_width  = 32,
  parameter int div_width  = 8,
  parameter int rst_cycles = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [cnt_width-1:0] cmd_count,
  input  logic [div_width-1:0] div,
  input  logic                 hold,
  output logic                 cke,
  output logic                 emu_rst,
  output logic                 busy,
  output logic                 done,
  output logic [cnt_width-1:0] steps_done
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_STEP  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_STOP      = 2'd0,
    OP_STEP_N    = 2'd1,
    OP_RUN       = 2'd2,
    OP_RESET_EMU = 2'd3
  } op_t;

  // rst_cnt only needs to reach rst_cycles-1; keep at least one bit.
  localparam int RST_W = (rst_cycles > 1) ? $clog2(rst_cycles) : 1;
  localparam logic [RST_W-1:0]     RST_LAST = RST_W'(rst_cycles - 1);
  localparam logic [RST_W-1:0]     RST_ONE  = RST_W'(1);
  localparam logic [cnt_width-1:0] CNT_ONE  = cnt_width'(1);
  localparam logic [div_width-1:0] DIV_ONE  = div_width'(1);

  state_t               r_state;
  logic [RST_W-1:0]     r_rst_cnt;
  logic [div_width-1:0] r_div_cnt;
  logic [div_width-1:0] r_div_q;
  logic [cnt_width-1:0] r_remaining;
  logic [cnt_width-1:0] r_steps_done;
  logic                 r_done;
  logic                 r_rst_by_cmd;   // RESET entered by RESET_EMU -> done on exit

  logic w_active;
  logic w_accept;
  logic w_div_hit;
  logic w_cke;

  // Output decodes of the registered state; cke also sees hold directly.
  assign w_active  = (r_state == S_STEP) || (r_state == S_RUN);
  assign w_div_hit = (r_div_cnt == r_div_q);
  assign w_cke     = w_active && !hold && w_div_hit;
  assign w_accept  = cmd_valid && cmd_ready;

  assign cmd_ready  = (r_state != S_RESET);
  assign emu_rst    = (r_state == S_RESET);
  assign busy       = (r_state != S_IDLE);
  assign cke        = w_cke;
  assign done       = r_done;
  assign steps_done = r_steps_done;

  // Sequencer FSM: state, reset timer, divider, step counters and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RESET;
      r_rst_cnt    <= '0;
      r_div_cnt    <= '0;
      r_div_q      <= '0;
      r_remaining  <= '0;
      r_steps_done <= '0;
      r_done       <= 1'b0;
      r_rst_by_cmd <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so a later assignment
      // in this block overrides an earlier one for the same edge (used below
      // to let RESET_EMU clear steps_done even on a counted cke).
      r_done <= 1'b0;
      unique case (r_state)
        S_RESET: begin
          r_steps_done <= '0;
          if (r_rst_cnt == RST_LAST) begin
            r_state      <= S_IDLE;
            r_done       <= r_rst_by_cmd;
            r_rst_by_cmd <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RST_ONE;
          end
        end

        S_IDLE: begin
          if (w_accept) begin
            unique case (op_t'(cmd_op))
              OP_STOP: ;
              OP_STEP_N: begin
                if (cmd_count != '0) begin
                  r_remaining <= cmd_count;
                  r_div_q     <= div;
                  r_div_cnt   <= '0;
                  r_state     <= S_STEP;
                end else begin
                  r_done <= 1'b1;
                end
              end
              OP_RUN: begin
                r_div_q   <= div;
                r_div_cnt <= '0;
                r_state   <= S_RUN;
              end
              OP_RESET_EMU: begin
                r_rst_cnt    <= '0;
                r_rst_by_cmd <= 1'b1;
                r_state      <= S_RESET;
              end
            endcase
          end
        end

        default: begin  // S_STEP, S_RUN
          if (!hold) begin
            r_div_cnt <= w_div_hit ? '0 : r_div_cnt + DIV_ONE;
          end
          if (w_cke) begin
            r_steps_done <= r_steps_done + CNT_ONE;
            if (r_state == S_STEP) begin
              r_remaining <= r_remaining - CNT_ONE;
            end
          end
          // STOP / RESET_EMU take priority over step completion.
          if (w_accept && (op_t'(cmd_op) == OP_STOP)) begin
            r_state <= S_IDLE;
          end else if (w_accept && (op_t'(cmd_op) == OP_RESET_EMU)) begin
            r_rst_cnt    <= '0;
            r_rst_by_cmd <= 1'b1;
            r_steps_done <= '0;
            r_state      <= S_RESET;
          end else if ((r_state == S_STEP) && w_cke && (r_remaining == CNT_ONE)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
